// File: rtl/demux_4_stream.sv
// demux_4_stream: registered 1-to-4 stream demultiplexer with valid/ready handshake.
//
// Each accepted input word is held in a single-entry register and presented on one of
// four output channels. The channel is in_sel, or an internal round-robin pointer when
// RR_MODE=1. One word per cycle is possible: a delivery and a new accept may happen on
// the same edge. Each channel has a wrapping count of the words delivered on it.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_data    input word
//   in_sel     destination channel (ignored when RR_MODE=1)
//   in_valid   input word present
//   in_ready   block can accept a word this cycle
//   out_data   channel k on [k*WIDTH +: WIDTH]; non-destination lanes drive 0
//   out_valid  one-hot (or zero) valid per channel
//   out_ready  per-channel consumer ready
//   cnt_flat   delivered-word count per channel, k on [k*CNT_W +: CNT_W]
module demux_4_stream #(
    parameter int unsigned WIDTH   = 4,
    parameter bit          RR_MODE = 1'b0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*CNT_W-1:0] cnt_flat
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic [1:0]         dest_q, dest_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q [4];
    logic [CNT_W-1:0]   cnt_d [4];

    logic               accept;
    logic               deliver;
    logic [1:0]         sel_eff;

    assign sel_eff  = RR_MODE ? rr_ptr_q : in_sel;
    // Only the destination channel's ready matters; the others are ignored.
    assign deliver  = (state_q == StFull) && out_ready[dest_q];
    assign in_ready = (state_q == StEmpty) || out_ready[dest_q];
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        dest_d   = dest_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (deliver && !accept) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (accept) begin
            hold_d   = in_data;
            dest_d   = sel_eff;
            rr_ptr_d = rr_ptr_q + 2'd1;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k];
            if (deliver && (dest_q == 2'(k))) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            hold_q   <= '0;
            dest_q   <= '0;
            rr_ptr_q <= '0;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            dest_q   <= dest_d;
            rr_ptr_q <= rr_ptr_d;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Outputs decode registered state only, so no in_data -> out_data path exists.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        cnt_flat  = '0;
        for (int k = 0; k < 4; k++) begin
            if ((state_q == StFull) && (dest_q == 2'(k))) begin
                out_valid[k]                = 1'b1;
                out_data[k*WIDTH +: WIDTH]  = hold_q;
            end
            cnt_flat[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

endmodule

// File: tb/tb_demux_4_stream.sv
// tb_demux_4_stream: drives one select-mode and one round-robin instance with the same
// stimulus. A transaction-level model (one pending word per instance, per-channel
// counts) predicts the outputs; a compare process checks both instances every cycle,
// and directed literal checks pin the model at key points.
module tb_demux_4_stream;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;

    logic               clk;
    logic               rst_n;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic [3:0]         out_ready;

    logic               in_ready_s, in_ready_r;
    logic [4*WIDTH-1:0] out_data_s, out_data_r;
    logic [3:0]         out_valid_s, out_valid_r;
    logic [4*CNT_W-1:0] cnt_s, cnt_r;

    int tests;
    int fails;

    demux_4_stream #(.WIDTH(WIDTH), .RR_MODE(1'b0), .CNT_W(CNT_W)) dut_sel (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready_s), .out_data(out_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .cnt_flat(cnt_s)
    );

    demux_4_stream #(.WIDTH(WIDTH), .RR_MODE(1'b1), .CNT_W(CNT_W)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready_r), .out_data(out_data_r),
        .out_valid(out_valid_r), .out_ready(out_ready), .cnt_flat(cnt_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: index 0 = select mode, 1 = round-robin. A pending word either exists or not.
    bit         m_full [2];
    logic [3:0] m_data [2];
    int         m_dest [2];
    int         m_ptr  [2];
    int         m_cnt  [2][4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                m_full[m] = 0; m_data[m] = '0; m_dest[m] = 0; m_ptr[m] = 0;
                for (int k = 0; k < 4; k++) m_cnt[m][k] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                bit can_take, gone;
                gone     = m_full[m] && out_ready[m_dest[m]];
                can_take = in_valid && (!m_full[m] || out_ready[m_dest[m]]);
                if (gone) m_cnt[m][m_dest[m]] = (m_cnt[m][m_dest[m]] + 1) % 256;
                if (can_take) begin
                    m_data[m] = in_data;
                    m_dest[m] = (m == 1) ? m_ptr[m] : int'(in_sel);
                    m_ptr[m]  = (m_ptr[m] + 1) % 4;
                    m_full[m] = 1;
                end else if (gone) begin
                    m_full[m] = 0;
                end
            end
        end
    end

    function automatic logic [63:0] exp_valid(input int m);
        return m_full[m] ? 64'(1 << m_dest[m]) : 64'd0;
    endfunction

    function automatic logic [63:0] exp_data(input int m);
        return m_full[m] ? (64'(m_data[m]) << (4 * m_dest[m])) : 64'd0;
    endfunction

    function automatic logic [63:0] exp_ready(input int m);
        return 64'(!m_full[m] || out_ready[m_dest[m]]);
    endfunction

    function automatic logic [63:0] exp_cnt(input int m);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v |= 64'(m_cnt[m][k]) << (8 * k);
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("sel in_ready",  64'(in_ready_s),  exp_ready(0));
            chk("sel out_valid", 64'(out_valid_s), exp_valid(0));
            chk("sel out_data",  64'(out_data_s),  exp_data(0));
            chk("sel cnt_flat",  64'(cnt_s),       exp_cnt(0));
            chk("rr in_ready",   64'(in_ready_r),  exp_ready(1));
            chk("rr out_valid",  64'(out_valid_r), exp_valid(1));
            chk("rr out_data",   64'(out_data_r),  exp_data(1));
            chk("rr cnt_flat",   64'(cnt_r),       exp_cnt(1));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reset with in_valid high: outputs must be idle during and after reset.
    task automatic do_reset();
        in_valid = 1'b1;
        in_data  = 4'h9;
        rst_n    = 1'b0;
        #1;
        chk("rst sel out_valid", 64'(out_valid_s), 64'd0);
        chk("rst rr out_valid",  64'(out_valid_r), 64'd0);
        chk("rst sel cnt",       64'(cnt_s),       64'd0);
        step();
        step();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rst sel in_ready",  64'(in_ready_s),  64'd1);
        chk("rst sel out_data",  64'(out_data_s),  64'd0);
        step();
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = 4'hF;
        #1;

        // 1 + 2: reset, then select-mode single word
        do_reset();
        out_ready = 4'hF; in_data = 4'hA; in_sel = 2'd2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t2 out_valid", 64'(out_valid_s), 64'h4);
        chk("t2 lane2",     64'(out_data_s[11:8]), 64'hA);
        chk("t2 other lanes", 64'(out_data_s & 16'hF0FF), 64'd0);
        step();
        chk("t2 cnt ch2",   64'(cnt_s[23:16]), 64'd1);
        chk("t2 idle",      64'(out_valid_s), 64'd0);

        // 3: backpressure with a waiting word
        do_reset();
        out_ready = 4'b1101; in_data = 4'h5; in_sel = 2'd1; in_valid = 1'b1;
        step();
        in_data = 4'h6; in_sel = 2'd3;
        for (int i = 0; i < 5; i++) begin
            chk("t3 in_ready",  64'(in_ready_s), 64'd0);
            chk("t3 hold lane1", 64'(out_data_s), 64'h0050);
            chk("t3 hold valid", 64'(out_valid_s), 64'h2);
            step();
        end
        out_ready = 4'hF;
        step();
        in_valid = 1'b0;
        chk("t3 next valid", 64'(out_valid_s), 64'h8);
        chk("t3 next lane3", 64'(out_data_s), 64'h6000);
        chk("t3 cnt ch1",    64'(cnt_s[15:8]), 64'd1);
        step();

        // 4: round-robin stream 1..6, in_sel ignored
        do_reset();
        out_ready = 4'hF; in_sel = 2'd3; in_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            in_data = 4'(i);
            step();
            if (i == 1) chk("t4 first rr ch0", 64'(out_valid_r), 64'h1);
        end
        in_valid = 1'b0;
        step();
        chk("t4 rr counts", 64'(cnt_r), 64'h0101_0202);

        // 5: counter wrap on ch0
        do_reset();
        out_ready = 4'hF; in_sel = 2'd0; in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 4'(i);
            step();
            if (i == 254) chk("t5 cnt ch0 pre-wrap", 64'(cnt_s[7:0]), 64'd254);
        end
        in_valid = 1'b0;
        step();
        chk("t5 wrap", 64'(cnt_s), 64'd0);

        // 6: reset while a word is held
        do_reset();
        out_ready = 4'h0; in_data = 4'hF; in_sel = 2'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("t6 held valid", 64'(out_valid_s), 64'h8);
        rst_n = 1'b0;
        #1;
        chk("t6 valid drop sel", 64'(out_valid_s), 64'd0);
        chk("t6 valid drop rr",  64'(out_valid_r), 64'd0);
        step();
        rst_n = 1'b1;
        out_ready = 4'hF;
        step();
        step();
        chk("t6 no valid", 64'(out_valid_s), 64'd0);
        chk("t6 cnt zero", 64'(cnt_s), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
